multibyte_addsub_seq: RTL and testbench

Sequencer that performs NBYTES-wide two's-complement add/subtract by iterating one shared 8-bit add/sub slice over the operands, one byte per cycle, LSB first. The carry is propagated between bytes in a register. The block sits between a requesting controller (start/done handshake) and the 8-bit carry-lookahead add/sub datapath. It reports full-width signed overflow and carry-out.

---
 rtl/multibyte_addsub_seq_pkg.sv | 18 +
 rtl/multibyte_addsub_seq_byte_addsub_slice.sv | 52 +++++
 rtl/multibyte_addsub_seq.sv | 116 +++++++++++
 tb/tb_multibyte_addsub_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/multibyte_addsub_seq_pkg.sv
// Shared constants for the multi-byte add/subtract sequencer and its 8-bit slice.
package multibyte_addsub_seq_pkg;

  localparam int BYTE_W = 8;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  function automatic logic signed_ovf(input logic c6, input logic c7);
    return c6 ^ c7;
  endfunction

endpackage

// File: rtl/multibyte_addsub_seq_byte_addsub_slice.sv
// Combinational 8-bit carry-lookahead add/subtract slice; b is inverted in subtract mode,
// the carry-in (1 for the first subtract byte) comes from the sequencer.
module byte_addsub_slice
  import multibyte_addsub_seq_pkg::*;
(
  input  logic              ci,
  input  logic              m,
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  output logic [BYTE_W-1:0] s,
  output logic              c6,
  output logic              c7
);

  logic [BYTE_W-1:0] bx_s;
  logic [BYTE_W-1:0] g_s;
  logic [BYTE_W-1:0] p_s;
  logic [BYTE_W:0]   c_s;

  // Generate/propagate terms and sum-of-products lookahead carries for every bit.
  always_comb begin
    logic acc_v;
    logic term_v;
    bx_s   = b ^ {BYTE_W{m}};
    g_s    = a & bx_s;
    p_s    = a ^ bx_s;
    c_s    = {(BYTE_W+1){1'b0}};
    c_s[0] = ci;
    acc_v  = 1'b0;
    term_v = 1'b0;
    for (int i = 0; i < BYTE_W; i++) begin
      term_v = ci;
      for (int j = 0; j <= i; j++) begin
        term_v = term_v & p_s[j];
      end
      acc_v = term_v;
      for (int j = 0; j <= i; j++) begin
        term_v = g_s[j];
        for (int k = j + 1; k <= i; k++) begin
          term_v = term_v & p_s[k];
        end
        acc_v = acc_v | term_v;
      end
      c_s[i+1] = acc_v;
    end
  end

  assign s  = p_s ^ c_s[BYTE_W-1:0];
  assign c6 = c_s[BYTE_W-1];
  assign c7 = c_s[BYTE_W];

endmodule

// File: rtl/multibyte_addsub_seq.sv
// NBYTES-wide add/subtract built by stepping one 8-bit slice over the operands,
// LSB byte first, with the inter-byte carry held in a register.
module multibyte_addsub_seq
  import multibyte_addsub_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   m,
  input  logic [8*NBYTES-1:0]    a,
  input  logic [8*NBYTES-1:0]    b,
  output logic                   busy,
  output logic                   done,
  output logic [8*NBYTES-1:0]    result,
  output logic                   ovf,
  output logic                   cout
);

  localparam int W    = BYTE_W * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [1:0]        state_r;
  logic [IDXW-1:0]   idx_r;
  logic              carry_r;
  logic              m_r;
  logic [W-1:0]      a_r;
  logic [W-1:0]      b_r;
  logic [W-1:0]      result_r;
  logic              busy_r;
  logic              done_r;
  logic              ovf_r;
  logic              cout_r;

  logic [BYTE_W-1:0] a_byte_s;
  logic [BYTE_W-1:0] b_byte_s;
  logic [BYTE_W-1:0] sum_s;
  logic              c6_s;
  logic              c7_s;
  logic              last_s;

  assign a_byte_s = a_r[idx_r*BYTE_W +: BYTE_W];
  assign b_byte_s = b_r[idx_r*BYTE_W +: BYTE_W];
  assign last_s   = (idx_r == IDXW'(NBYTES - 1));

  byte_addsub_slice u_slice (
    .ci (carry_r),
    .m  (m_r),
    .a  (a_byte_s),
    .b  (b_byte_s),
    .s  (sum_s),
    .c6 (c6_s),
    .c7 (c7_s)
  );

  // Sequencer: accept, one byte per RUN cycle, single-cycle DONE pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      idx_r    <= {IDXW{1'b0}};
      carry_r  <= 1'b0;
      m_r      <= MODE_ADD;
      a_r      <= {W{1'b0}};
      b_r      <= {W{1'b0}};
      result_r <= {W{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      ovf_r    <= 1'b0;
      cout_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            m_r     <= m;
            idx_r   <= {IDXW{1'b0}};
            carry_r <= m;
            busy_r  <= 1'b1;
            state_r <= RUN;
          end
        end
        RUN: begin
          result_r[idx_r*BYTE_W +: BYTE_W] <= sum_s;
          carry_r <= c7_s;
          if (last_s) begin
            ovf_r   <= signed_ovf(c6_s, c7_s);
            cout_r  <= c7_s;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            idx_r <= idx_r + IDXW'(1);
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
  assign ovf    = ovf_r;
  assign cout   = cout_r;

endmodule

// File: tb/tb_multibyte_addsub_seq.sv
// Scoreboard bench: directed add/subtract vectors on a 4-byte and a 2-byte instance.
module tb_multibyte_addsub_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4, start4, m4, busy4, done4, ovf4, cout4;
  logic [31:0] a4, b4, result4;
  logic        rst2, start2, m2, busy2, done2, ovf2, cout2;
  logic [15:0] a2, b2, result2;

  multibyte_addsub_seq #(.NBYTES(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .m(m4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(result4), .ovf(ovf4), .cout(cout4)
  );

  multibyte_addsub_seq #(.NBYTES(2)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .m(m2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .result(result2), .ovf(ovf2), .cout(cout2)
  );

  typedef struct {
    logic [31:0] r;
    logic        o;
    logic        c;
  } exp_t;

  exp_t q4[$];
  exp_t q2[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: bound expired or unexpected event", nm);
  endtask

  // Monitor for the 4-byte instance.
  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      exp_t e;
      if (q4.size() == 0) begin
        fail_now("done4_unexpected");
      end else begin
        e = q4.pop_front();
        check("res4", result4, e.r);
        check("ovf4", 32'(ovf4), 32'(e.o));
        check("cout4", 32'(cout4), 32'(e.c));
      end
    end
  end

  // Monitor for the 2-byte instance.
  always @(negedge clk) begin
    if (done2 === 1'b1) begin
      exp_t e;
      if (q2.size() == 0) begin
        fail_now("done2_unexpected");
      end else begin
        e = q2.pop_front();
        check("res2", 32'(result2), e.r);
        check("ovf2", 32'(ovf2), 32'(e.o));
        check("cout2", 32'(cout2), 32'(e.c));
      end
    end
  end

  // One operation on instance sel (4 or 2); checks latency, busy length and pulse width.
  task automatic op(input int sel, input logic mm, input logic [31:0] aa, input logic [31:0] bb,
                    input logic [31:0] er, input logic eo, input logic ec, input bit poke,
                    input string nm);
    exp_t e;
    int   n;
    int   nb;
    logic dn;
    e.r = er;
    e.o = eo;
    e.c = ec;
    if (sel == 4) begin
      q4.push_back(e);
      m4 = mm; a4 = aa; b4 = bb; start4 = 1'b1;
    end else begin
      q2.push_back(e);
      m2 = mm; a2 = aa[15:0]; b2 = bb[15:0]; start2 = 1'b1;
    end
    @(posedge clk);
    #1;
    start4 = 1'b0; start2 = 1'b0;
    a4 = 32'hDEADBEEF; b4 = 32'hCAFEF00D; m4 = ~mm;
    a2 = 16'hBEEF;     b2 = 16'hF00D;     m2 = ~mm;
    n  = 0;
    nb = 0;
    dn = 1'b0;
    while (!dn && n < 20) begin
      @(negedge clk);
      n++;
      dn = (sel == 4) ? done4 : done2;
      if (((sel == 4) ? busy4 : busy2) === 1'b1) nb++;
      if (poke && n == 2) start4 = 1'b1;
      if (poke && n == 3) start4 = 1'b0;
    end
    if (!dn) begin
      fail_now({nm, "_timeout"});
    end else begin
      check({nm, "_latency"}, 32'(n), 32'(sel + 1));
      check({nm, "_busy_cycles"}, 32'(nb), 32'(sel));
      @(negedge clk);
      check({nm, "_done_width"}, 32'((sel == 4) ? done4 : done2), 32'd0);
    end
  endtask

  logic [31:0] hold_exp [3];
  int          cyc;
  int          last;
  bit          found;

  initial begin
    hold_exp[0] = 32'h00000003;
    hold_exp[1] = 32'h00000002;
    hold_exp[2] = 32'h00000000;
    rst4 = 1'b1; start4 = 1'b0; m4 = 1'b0; a4 = 32'h0; b4 = 32'h0;
    rst2 = 1'b1; start2 = 1'b0; m2 = 1'b0; a2 = 16'h0; b2 = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy4", 32'(busy4), 32'd0);
    check("rst_done4", 32'(done4), 32'd0);
    check("rst_result4", result4, 32'd0);
    check("rst_ovf4", 32'(ovf4), 32'd0);
    check("rst_cout4", 32'(cout4), 32'd0);
    check("rst_result2", 32'(result2), 32'd0);
    rst4 = 1'b0; rst2 = 1'b0;
    @(negedge clk);

    op(4, 1'b0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0, 1'b0, "carry_byte");
    repeat (3) @(negedge clk);
    check("hold_result4", result4, 32'h00000100);
    op(4, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1'b0, "add_ovf");
    op(4, 1'b1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, "sub_borrow");
    check("hold_cout4", 32'(cout4), 32'd0);
    op(4, 1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, "sub_ovf");
    op(4, 1'b0, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0, 1'b1, "start_busy");

    // Abort in RUN cycle 2: no done pulse may follow.
    m4 = 1'b0; a4 = 32'h01010101; b4 = 32'h01010101; start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst4 = 1'b1;
    @(posedge clk);
    #1;
    rst4 = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy4), 32'd0);
    check("abort_done", 32'(done4), 32'd0);
    check("abort_result", result4, 32'd0);
    repeat (8) @(negedge clk);
    op(4, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0, "after_abort");

    // Start held high: back-to-back operations every NBYTES+2 cycles.
    e_push(32'h00000003, 1'b0, 1'b0);
    e_push(32'h00000002, 1'b0, 1'b1);
    e_push(32'h00000000, 1'b1, 1'b1);
    m4 = 1'b0; a4 = 32'h00000001; b4 = 32'h00000002; start4 = 1'b1;
    cyc  = 0;
    last = 0;
    for (int k = 0; k < 3; k++) begin
      found = 1'b0;
      while (!found && cyc < 200) begin
        @(negedge clk);
        cyc++;
        if (done4 === 1'b1) found = 1'b1;
      end
      if (!found) begin
        fail_now("b2b_timeout");
      end else begin
        if (k > 0) check("b2b_spacing", 32'(cyc - last), 32'd6);
        last = cyc;
        if (k == 0) begin m4 = 1'b1; a4 = 32'h00000005; b4 = 32'h00000003; end
        if (k == 1) begin m4 = 1'b0; a4 = 32'h80000000; b4 = 32'h80000000; end
        if (k == 2) start4 = 1'b0;
        @(negedge clk);
        cyc++;
        check("b2b_hold", result4, hold_exp[k]);
      end
    end

    op(2, 1'b0, 32'h7FFF, 32'h0001, 32'h8000, 1'b1, 1'b0, 1'b0, "n2_add_ovf");
    op(2, 1'b0, 32'h00FF, 32'h0001, 32'h0100, 1'b0, 1'b0, 1'b0, "n2_carry");
    op(2, 1'b1, 32'h0000, 32'h0001, 32'hFFFF, 1'b0, 1'b0, 1'b0, "n2_borrow");
    op(2, 1'b1, 32'h8000, 32'h0001, 32'h7FFF, 1'b1, 1'b1, 1'b0, "n2_sub_ovf");
    op(2, 1'b0, 32'hFFFF, 32'h0001, 32'h0000, 1'b0, 1'b1, 1'b0, "n2_wrap");

    repeat (4) @(negedge clk);
    check("q4_drained", 32'(q4.size()), 32'd0);
    check("q2_drained", 32'(q2.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  task automatic e_push(input logic [31:0] r, input logic o, input logic c);
    exp_t e;
    e.r = r;
    e.o = o;
    e.c = c;
    q4.push_back(e);
  endtask

endmodule
